// File: rtl/mem_line_resp_pkg.sv
// mem_line_resp_pkg: shared constants and FSM state type for the line responder slice.
package mem_line_resp_pkg;

   localparam int unsigned ADDR_W         = 48;
   localparam int unsigned LINE_W         = 64;
   localparam int unsigned DEF_LATENCY    = 4;
   localparam int unsigned DEF_LINE_IDX_W = 10;
   localparam int unsigned CNT_W          = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/mem_line_responder_if.sv
// mem_line_responder_if: cache-controller <-> line responder request/response bundle.
interface mem_line_responder_if;
   import mem_line_resp_pkg::*;

   logic              req;
   logic              req_rw;
   logic [ADDR_W-1:0] req_addr;
   logic [LINE_W-1:0] wr_line;
   logic [LINE_W-1:0] rd_line;
   logic              ack;
   logic              busy;
   logic              err;

   modport master (
      output req, req_rw, req_addr, wr_line,
      input  rd_line, ack, busy, err
   );

   modport slave (
      input  req, req_rw, req_addr, wr_line,
      output rd_line, ack, busy, err
   );

endinterface

// File: rtl/mem_line_array.sv
// mem_line_array: single-port synchronous line store with registered read.
module mem_line_array
   import mem_line_resp_pkg::*;
#(
   parameter int unsigned LINE_IDX_W = DEF_LINE_IDX_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  we,
   input  logic [LINE_IDX_W-1:0] idx,
   input  logic [LINE_W-1:0]     wdata,
   output logic [LINE_W-1:0]     rdata
);

   logic [LINE_W-1:0] mem [2**LINE_IDX_W];

   // Write port; contents are never touched by reset.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[idx] <= wdata;
      end
   end

   // Registered read; the output only moves on a read access and clears on reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/mem_line_responder.sv
// mem_line_responder: fixed-latency line read/write responder in front of mem_line_array.
// Optional out-of-range checking is enabled by defining MEM_LINE_RESP_RANGE_CHECK_EN.
module mem_line_responder
   import mem_line_resp_pkg::*;
#(
   parameter int unsigned LINE_IDX_W = DEF_LINE_IDX_W,
   parameter int unsigned LATENCY    = DEF_LATENCY
) (
   input  logic           clk,
   input  logic           gen_reset_n,
   mem_line_responder_if.slave bus
);

   state_t                state;
   state_t                state_nxt;
   logic [CNT_W-1:0]      cnt;
   logic                  rw_q;
   logic [LINE_IDX_W-1:0] idx_q;
   logic [LINE_W-1:0]     wdata_q;
   logic                  oob_q;
   logic                  rd_zero_q;
   logic                  oob_req;
   logic                  accept;
   logic                  access;
   logic                  ram_en;
   logic [LINE_W-1:0]     ram_rdata;
   logic                  unused_addr_bits;

`ifdef MEM_LINE_RESP_RANGE_CHECK_EN
   assign oob_req          = |bus.req_addr[ADDR_W-1:LINE_IDX_W+2];
   assign unused_addr_bits = ^bus.req_addr[1:0];
`else
   assign oob_req          = 1'b0;
   assign unused_addr_bits = ^{bus.req_addr[ADDR_W-1:LINE_IDX_W+2], bus.req_addr[1:0]};
`endif

   assign accept = (state == IDLE) && bus.req;
   assign access = (state == WAIT) && (cnt == '0);
   // A reset edge that coincides with the access edge must not commit the write.
   assign ram_en = access && gen_reset_n && !oob_q;

   // State register.
   always_ff @(posedge clk) begin
      if (!gen_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.req) state_nxt = WAIT;
         WAIT:    if (cnt == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, wait counter and read-data masking flag.
   always_ff @(posedge clk) begin
      if (!gen_reset_n) begin
         cnt       <= '0;
         rd_zero_q <= 1'b0;
      end else begin
         if (accept) begin
            cnt     <= CNT_W'(LATENCY - 1);
            rw_q    <= bus.req_rw;
            idx_q   <= bus.req_addr[LINE_IDX_W+1:2];
            wdata_q <= bus.wr_line;
            oob_q   <= oob_req;
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         // Out-of-range requests present zero; good reads unmask the array output.
         if (access && (oob_q || !rw_q)) begin
            rd_zero_q <= oob_q;
         end
      end
   end

   // Outputs decoded from state.
   always_comb begin
      bus.busy    = (state != IDLE);
      bus.ack     = (state == RESP);
      bus.err     = (state == RESP) && oob_q;
      bus.rd_line = rd_zero_q ? '0 : ram_rdata;
   end

   mem_line_array #(
      .LINE_IDX_W (LINE_IDX_W)
   ) u_array (
      .clk   (clk),
      .rst_n (gen_reset_n),
      .en    (ram_en),
      .we    (rw_q),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: randomized self-checking bench for mem_line_responder.
module tb_mem_line_responder;
   import mem_line_resp_pkg::*;

   localparam int unsigned LAT  = 4;
   localparam int unsigned IDXW = 10;
   localparam int unsigned NLINES = 1024;

   logic clk = 1'b0;
   logic gen_reset_n;

   always #5 clk = ~clk;

   mem_line_responder_if bus ();
   mem_line_responder_if bus1 ();

   mem_line_responder #(.LINE_IDX_W(IDXW), .LATENCY(LAT)) dut (
      .clk         (clk),
      .gen_reset_n (gen_reset_n),
      .bus         (bus)
   );

   mem_line_responder #(.LINE_IDX_W(IDXW), .LATENCY(1)) dut1 (
      .clk         (clk),
      .gen_reset_n (gen_reset_n),
      .bus         (bus1)
   );

   int checks = 0;
   int errors = 0;

   logic [63:0] model_mem [NLINES];
   logic [63:0] rd_exp;

   function automatic bit addr_oob(input logic [47:0] a);
`ifdef MEM_LINE_RESP_RANGE_CHECK_EN
      return (a >> 12) != 48'd0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int unsigned line_of(input logic [47:0] a);
      return int'((a >> 2) % 48'd1024);
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // One complete request on the LATENCY=4 instance, checked cycle by cycle.
   task automatic do_txn(input bit rw, input logic [47:0] addr, input logic [63:0] data, input bit intrude);
      bit          oob;
      int unsigned idx;
      logic [63:0] rd_old;
      logic [63:0] rd_new;
      logic        exp_busy;
      logic        exp_ack;
      logic [63:0] exp_rd;
      oob    = addr_oob(addr);
      idx    = line_of(addr);
      rd_old = rd_exp;
      if (oob)      rd_new = '0;
      else if (!rw) rd_new = model_mem[idx];
      else          rd_new = rd_old;
      @(negedge clk);
      bus.req = 1'b1; bus.req_rw = rw; bus.req_addr = addr; bus.wr_line = data;
      @(posedge clk); #1;
      bus.req = 1'b0;
      for (int k = 1; k <= int'(LAT) + 2; k++) begin
         exp_busy = (k <= int'(LAT) + 1);
         exp_ack  = (k == int'(LAT) + 1);
         exp_rd   = (k <= int'(LAT)) ? rd_old : rd_new;
         checks++;
         if (bus.busy !== exp_busy) begin
            errors++;
            $display("FAIL txn_busy k=%0d addr=%h: got %b expected %b", k, addr, bus.busy, exp_busy);
         end
         checks++;
         if (bus.ack !== exp_ack) begin
            errors++;
            $display("FAIL txn_ack k=%0d addr=%h: got %b expected %b", k, addr, bus.ack, exp_ack);
         end
         checks++;
         if (bus.rd_line !== exp_rd) begin
            errors++;
            $display("FAIL txn_rd_line k=%0d addr=%h: got %h expected %h", k, addr, bus.rd_line, exp_rd);
         end
         if (exp_ack) begin
            checks++;
            if (bus.err !== oob) begin
               errors++;
               $display("FAIL txn_err addr=%h: got %b expected %b", addr, bus.err, oob);
            end
         end
         if (intrude && k == 2) begin
            bus.req = 1'b1; bus.req_rw = 1'b1; bus.req_addr = 48'h1C;
            bus.wr_line = 64'hDEAD_BEEF_DEAD_BEEF;
         end
         if (intrude && k == 3) bus.req = 1'b0;
         @(posedge clk); #1;
      end
      if (rw && !oob) model_mem[idx] = data;
      rd_exp = rd_new;
   endtask

   task automatic test_reset();
      gen_reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.busy, bus.ack, bus.err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.ack, bus.err});
      end
      checks++;
      if (bus.rd_line !== 64'h0) begin
         errors++;
         $display("FAIL reset_rd_line: got %h expected 0", bus.rd_line);
      end
      checks++;
      if ({bus1.busy, bus1.ack, bus1.err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags_lat1: got %b expected 000", {bus1.busy, bus1.ack, bus1.err});
      end
      @(negedge clk);
      gen_reset_n = 1'b1;
      rd_exp = '0;
   endtask

   task automatic test_write_read();
      do_txn(1'b1, 48'h10, 64'h0123456789ABCDEF, 1'b0);
      do_txn(1'b0, 48'h13, 64'h0, 1'b0);
      checks++;
      if (bus.rd_line !== 64'h0123456789ABCDEF) begin
         errors++;
         $display("FAIL write_read_data: got %h expected 0123456789abcdef", bus.rd_line);
      end
   endtask

   task automatic test_random_traffic();
      logic [47:0] addr;
      logic [35:0] hi;
      for (int n = 0; n < 30; n++) begin
         hi = ($urandom_range(0, 7) == 0) ? 36'({$urandom, $urandom}) : 36'h0;
         addr = (48'(hi) << 12) | (48'($urandom_range(0, 15)) << 2) | 48'($urandom_range(0, 3));
         do_txn(1'($urandom_range(0, 1)), addr, rand64(), 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned idx;
      int unsigned p;
      int          acks;
      logic [63:0] exp;
      logic        exp_busy;
      logic        exp_ack;
      idx  = $urandom_range(0, NLINES - 1);
      exp  = model_mem[idx];
      p    = LAT + 2;
      acks = 0;
      @(negedge clk);
      bus.req = 1'b1; bus.req_rw = 1'b0; bus.req_addr = 48'(idx) << 2;
      @(posedge clk); #1;
      for (int k = 1; k <= 3 * int'(p); k++) begin
         exp_busy = (k < 3 * int'(p)) && (k % int'(p) != 0);
         exp_ack  = (k < 3 * int'(p)) && (k % int'(p) == int'(LAT) + 1);
         checks++;
         if (bus.busy !== exp_busy) begin
            errors++;
            $display("FAIL b2b_busy k=%0d: got %b expected %b", k, bus.busy, exp_busy);
         end
         checks++;
         if (bus.ack !== exp_ack) begin
            errors++;
            $display("FAIL b2b_ack k=%0d: got %b expected %b", k, bus.ack, exp_ack);
         end
         if (bus.ack === 1'b1) begin
            acks++;
            checks++;
            if (bus.rd_line !== exp) begin
               errors++;
               $display("FAIL b2b_rd_line k=%0d: got %h expected %h", k, bus.rd_line, exp);
            end
         end
         if (k == 2 * int'(p) + 1) bus.req = 1'b0;
         @(posedge clk); #1;
      end
      checks++;
      if (acks != 3) begin
         errors++;
         $display("FAIL b2b_ack_count: got %0d expected 3", acks);
      end
      rd_exp = exp;
   endtask

   task automatic test_busy_ignore();
      logic [63:0] a;
      logic [63:0] b;
      a = rand64();
      b = rand64();
      do_txn(1'b1, 48'h10, a, 1'b0);
      do_txn(1'b1, 48'h1C, b, 1'b0);
      do_txn(1'b0, 48'h10, 64'h0, 1'b1);
      do_txn(1'b0, 48'h1C, 64'h0, 1'b0);
      checks++;
      if (bus.rd_line !== b) begin
         errors++;
         $display("FAIL busy_ignore_idx7: got %h expected %h", bus.rd_line, b);
      end
   endtask

   task automatic test_range();
      logic [63:0] d;
      d = rand64();
      do_txn(1'b1, 48'h1000, d, 1'b0);
      do_txn(1'b0, 48'h0, 64'h0, 1'b0);
      checks++;
`ifdef MEM_LINE_RESP_RANGE_CHECK_EN
      if (bus.rd_line === d) begin
         errors++;
         $display("FAIL range_idx0: got %h expected untouched value", bus.rd_line);
      end
`else
      if (bus.rd_line !== d) begin
         errors++;
         $display("FAIL range_idx0: got %h expected %h", bus.rd_line, d);
      end
`endif
   endtask

   task automatic test_reset_mid_write();
      logic [63:0] prior;
      prior = rand64();
      while (prior == 64'hFFFF) prior = rand64();
      do_txn(1'b1, 48'h8, prior, 1'b0);
      @(negedge clk);
      bus.req = 1'b1; bus.req_rw = 1'b1; bus.req_addr = 48'h8; bus.wr_line = 64'hFFFF;
      @(posedge clk); #1;
      bus.req = 1'b0;
      @(negedge clk);
      gen_reset_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({bus.busy, bus.ack} !== 2'b00) begin
         errors++;
         $display("FAIL midreset_flags: got %b expected 00", {bus.busy, bus.ack});
      end
      checks++;
      if (bus.rd_line !== 64'h0) begin
         errors++;
         $display("FAIL midreset_rd_line: got %h expected 0", bus.rd_line);
      end
      @(negedge clk);
      gen_reset_n = 1'b1;
      for (int k = 0; k < int'(LAT) + 3; k++) begin
         @(posedge clk); #1;
         checks++;
         if ({bus.busy, bus.ack} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_quiet k=%0d: got %b expected 00", k, {bus.busy, bus.ack});
         end
      end
      rd_exp = '0;
      do_txn(1'b0, 48'h8, 64'h0, 1'b0);
      checks++;
      if (bus.rd_line !== prior) begin
         errors++;
         $display("FAIL midreset_idx2: got %h expected %h", bus.rd_line, prior);
      end
   endtask

   task automatic test_min_latency();
      logic [63:0] d;
      logic        exp_busy;
      logic        exp_ack;
      d = rand64();
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         bus1.req = 1'b1; bus1.req_rw = (t == 0); bus1.req_addr = 48'hFFC; bus1.wr_line = d;
         @(posedge clk); #1;
         bus1.req = 1'b0;
         for (int k = 1; k <= 3; k++) begin
            exp_busy = (k <= 2);
            exp_ack  = (k == 2);
            checks++;
            if (bus1.busy !== exp_busy) begin
               errors++;
               $display("FAIL minlat_busy t=%0d k=%0d: got %b expected %b", t, k, bus1.busy, exp_busy);
            end
            checks++;
            if (bus1.ack !== exp_ack) begin
               errors++;
               $display("FAIL minlat_ack t=%0d k=%0d: got %b expected %b", t, k, bus1.ack, exp_ack);
            end
            if (t == 1 && k == 2) begin
               checks++;
               if (bus1.rd_line !== d) begin
                  errors++;
                  $display("FAIL minlat_data: got %h expected %h", bus1.rd_line, d);
               end
            end
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < int'(NLINES); i++) model_mem[i] = '0;
      rd_exp = '0;
      gen_reset_n = 1'b0;
      bus.req = 1'b0;  bus.req_rw = 1'b0;  bus.req_addr = '0;  bus.wr_line = '0;
      bus1.req = 1'b0; bus1.req_rw = 1'b0; bus1.req_addr = '0; bus1.wr_line = '0;
      test_reset();
      test_write_read();
      test_random_traffic();
      test_back_to_back();
      test_busy_ignore();
      test_range();
      test_reset_mid_write();
      test_min_latency();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
